stream_radix_parser: RTL and testbench

STREAM_RADIX_PARSER -- requirements
Module: stream_radix_parser

---
 rtl/stream_radix_parser.sv | 192 +++++++++++++++++++
 tb/tb_stream_radix_parser.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_radix_parser.sv
// Streaming ASCII-to-binary converter: one character per transfer, MSD first,
// any radix 2..36, with sticky character/base/overflow error reporting per frame.
module stream_radix_parser #(
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned MAX_DIGITS = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [7:0]                       in_char,
    input  logic                             in_last,
    input  logic [5:0]                       base,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 out_value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]  out_ndigits,
    output logic                             out_err_char,
    output logic                             out_err_base,
    output logic                             out_overflow
);

    localparam int unsigned    NDW    = $clog2(MAX_DIGITS + 1);
    localparam logic [NDW-1:0] ND_MAX = NDW'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t           r_state;
    logic [5:0]       r_base;
    logic [OUT_W-1:0] r_acc;
    logic [NDW-1:0]   r_ndigits;
    logic             r_err_char;
    logic             r_err_base;
    logic             r_ovf;
    logic             r_seen_sig;

    state_t           w_state_n;
    logic [5:0]       w_base_n;
    logic [OUT_W-1:0] w_acc_n;
    logic [NDW-1:0]   w_ndigits_n;
    logic             w_err_char_n;
    logic             w_err_base_n;
    logic             w_ovf_n;
    logic             w_seen_sig_n;

    logic             w_xfer;
    logic             w_first;
    logic             w_dec_ok;
    logic [5:0]       w_dec_val;
    logic             w_is_nul;
    logic [5:0]       w_base_sel;
    logic             w_base_bad;
    logic             w_digit_ok;
    logic [OUT_W-1:0] w_acc_in;
    logic [NDW-1:0]   w_nd_in;
    logic             w_ovf_in;
    logic             w_seen_in;
    logic             w_sig;
    logic [OUT_W+5:0] w_prod;
    logic             w_prod_ovf;
    logic             w_cnt_ovf;

    assign in_ready     = (r_state != DONE);
    assign out_valid    = (r_state == DONE);
    assign out_value    = (r_err_char || r_err_base) ? '0 : (r_ovf ? '1 : r_acc);
    assign out_ndigits  = r_ndigits;
    assign out_err_char = r_err_char;
    assign out_err_base = r_err_base;
    assign out_overflow = r_ovf;

    always_comb begin
        w_dec_ok  = 1'b0;
        w_dec_val = '0;
        if (in_char >= 8'h30 && in_char <= 8'h39) begin
            w_dec_ok  = 1'b1;
            w_dec_val = 6'(in_char - 8'h30);
        end else if (in_char >= 8'h41 && in_char <= 8'h5A) begin
            w_dec_ok  = 1'b1;
            w_dec_val = 6'(in_char - 8'h37);
        end else if (in_char >= 8'h61 && in_char <= 8'h7A) begin
            w_dec_ok  = 1'b1;
            w_dec_val = 6'(in_char - 8'h57);
        end
    end

    // On the first character of a frame the registered context is stale, so
    // the arithmetic uses the live base input and a cleared accumulator.
    assign w_xfer     = in_valid && in_ready;
    assign w_first    = (r_state == IDLE);
    assign w_is_nul   = (in_char == 8'h00);
    assign w_base_sel = w_first ? base : r_base;
    assign w_base_bad = (w_base_sel < 6'd2) || (w_base_sel > 6'd36);
    assign w_digit_ok = w_dec_ok && (w_dec_val < w_base_sel);
    assign w_acc_in   = w_first ? '0 : r_acc;
    assign w_nd_in    = w_first ? '0 : r_ndigits;
    assign w_ovf_in   = w_first ? 1'b0 : r_ovf;
    assign w_seen_in  = w_first ? 1'b0 : r_seen_sig;
    assign w_sig      = w_seen_in || (w_dec_val != 6'd0);
    assign w_prod     = {6'b0, w_acc_in} * {{OUT_W{1'b0}}, w_base_sel}
                      + {{OUT_W{1'b0}}, w_dec_val};
    assign w_prod_ovf = |w_prod[OUT_W+5:OUT_W];
    assign w_cnt_ovf  = w_sig && (w_nd_in == ND_MAX);

    always_comb begin
        w_state_n    = r_state;
        w_base_n     = r_base;
        w_acc_n      = r_acc;
        w_ndigits_n  = r_ndigits;
        w_err_char_n = r_err_char;
        w_err_base_n = r_err_base;
        w_ovf_n      = r_ovf;
        w_seen_sig_n = r_seen_sig;

        if (w_xfer && w_first) begin
            w_base_n     = base;
            w_acc_n      = '0;
            w_ndigits_n  = '0;
            w_err_char_n = 1'b0;
            w_err_base_n = 1'b0;
            w_ovf_n      = 1'b0;
            w_seen_sig_n = 1'b0;
        end

        case (r_state)
            IDLE, ACCUM: begin
                if (w_xfer) begin
                    if (w_first && w_base_bad) begin
                        w_err_base_n = 1'b1;
                        w_state_n    = DRAIN;
                    end else if (w_is_nul) begin
                        w_state_n = ACCUM;
                    end else if (!w_digit_ok) begin
                        w_err_char_n = 1'b1;
                        w_state_n    = DRAIN;
                    end else begin
                        w_state_n = ACCUM;
                        if (w_sig) begin
                            w_seen_sig_n = 1'b1;
                            if (!w_cnt_ovf) begin
                                w_ndigits_n = w_nd_in + NDW'(1);
                            end
                        end
                        w_ovf_n = w_ovf_in || w_prod_ovf || w_cnt_ovf;
                        w_acc_n = (w_ovf_in || w_prod_ovf || w_cnt_ovf) ? '1 : w_prod[OUT_W-1:0];
                    end
                    if (in_last) begin
                        w_state_n = DONE;
                    end
                end
            end
            DRAIN: begin
                if (w_xfer && in_last) begin
                    w_state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_acc      <= '0;
            r_ndigits  <= '0;
            r_err_char <= 1'b0;
            r_err_base <= 1'b0;
            r_ovf      <= 1'b0;
            r_seen_sig <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_base     <= w_base_n;
            r_acc      <= w_acc_n;
            r_ndigits  <= w_ndigits_n;
            r_err_char <= w_err_char_n;
            r_err_base <= w_err_base_n;
            r_ovf      <= w_ovf_n;
            r_seen_sig <= w_seen_sig_n;
        end
    end

endmodule

// File: tb/tb_stream_radix_parser.sv
// Bench for stream_radix_parser: table of frames with hand-derived results,
// scoreboard queue filled when a frame is driven and drained by an output monitor.
module tb_stream_radix_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        in_last;
    logic [5:0]  in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [4:0]  out_ndigits;
    logic        out_err_char;
    logic        out_err_base;
    logic        out_overflow;

    always #5 clk = ~clk;

    stream_radix_parser #(.OUT_W(32), .MAX_DIGITS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_char     (in_char),
        .in_last     (in_last),
        .base        (in_base),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_ndigits (out_ndigits),
        .out_err_char(out_err_char),
        .out_err_base(out_err_base),
        .out_overflow(out_overflow)
    );

    typedef struct {
        logic [255:0] s;
        int           len;
        logic [5:0]   b;
        logic [31:0]  val;
        logic [4:0]   nd;
        logic         ec;
        logic         eb;
        logic         ov;
    } vec_t;

    typedef struct {
        logic [31:0] val;
        logic [4:0]  nd;
        logic        ec;
        logic        eb;
        logic        ov;
    } exp_t;

    vec_t vecs[$];
    vec_t tv;
    exp_t sb[$];
    exp_t me;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_result: got value 0x%0h, want no result", out_value);
            end else begin
                me = sb.pop_front();
                chk("out_value",    out_value,            me.val);
                chk("out_ndigits",  32'(out_ndigits),     32'(me.nd));
                chk("out_err_char", 32'(out_err_char),    32'(me.ec));
                chk("out_err_base", 32'(out_err_base),    32'(me.eb));
                chk("out_overflow", 32'(out_overflow),    32'(me.ov));
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the char.
    task automatic wait_accept();
        int cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready 0, want 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),     32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid),    32'd0);
        chk({tag, "_value"},     out_value,         32'd0);
        chk({tag, "_ndigits"},   32'(out_ndigits),  32'd0);
        chk({tag, "_flags"},     32'({out_err_char, out_err_base, out_overflow}), 32'd0);
    endtask

    // Later characters carry an illegal base to show it is only sampled once per frame.
    task automatic send_frame(input vec_t v, input int nsend);
        if (nsend == v.len) begin
            sb.push_back(exp_t'{v.val, v.nd, v.ec, v.eb, v.ov});
        end
        for (int i = 0; i < nsend; i++) begin
            in_valid = 1'b1;
            in_char  = v.s[8*(v.len-1-i) +: 8];
            in_last  = (i == v.len - 1);
            in_base  = (i == 0) ? v.b : 6'd1;
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_char  = 8'h00;
        if (nsend == v.len) begin
            @(negedge clk);
            chk("latency_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        //            chars                              len base    value          nd  ec  eb  ov
        vecs.push_back('{"1010",                           4, 6'd2,  32'd10,        5'd4,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"7f",                             2, 6'd16, 32'd127,       5'd2,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"1A3F",                           4, 6'd16, 32'd6719,      5'd4,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"1234",                           4, 6'd8,  32'd668,       5'd4,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"Zz",                             2, 6'd36, 32'd1295,      5'd2,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"7",                              1, 6'd10, 32'd7,         5'd1,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{{"12", 8'h00, "3"},               4, 6'd10, 32'd123,       5'd3,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{256'd0,                           1, 6'd10, 32'd0,         5'd0,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{"4294967295",                    10, 6'd10, 32'hFFFFFFFF,  5'd10, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"4294967296",                    10, 6'd10, 32'hFFFFFFFF,  5'd10, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"FFFFFFFFF",                      9, 6'd16, 32'hFFFFFFFF,  5'd9,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{{"0000000000", "00000001"},      18, 6'd10, 32'd1,         5'd1,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{{"1111111111", "1111111"},       17, 6'd2,  32'hFFFFFFFF,  5'd16, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"G1",                             2, 6'd16, 32'd0,         5'd0,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"9",                              1, 6'd8,  32'd0,         5'd0,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"#5",                             2, 6'd10, 32'd0,         5'd0,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{"123",                            3, 6'd1,  32'd0,         5'd0,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{"1",                              1, 6'd37, 32'd0,         5'd0,  1'b0, 1'b1, 1'b0});

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        in_last   = 1'b0;
        in_base   = 6'd10;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_cleared("reset");
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            send_frame(vecs[k], vecs[k].len);
        end

        // Back-pressure: result must hold while a pending char waits outside.
        out_ready = 1'b0;
        tv = '{"7f", 2, 6'd16, 32'd127, 5'd2, 1'b0, 1'b0, 1'b0};
        send_frame(tv, 2);
        in_valid = 1'b1;
        in_char  = "9";
        in_last  = 1'b1;
        in_base  = 6'd10;
        sb.push_back(exp_t'{32'd9, 5'd1, 1'b0, 1'b0, 1'b0});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid),   32'd1);
            chk("stall_in_ready",  32'(in_ready),    32'd0);
            chk("stall_value",     out_value,        32'd127);
            chk("stall_ndigits",   32'(out_ndigits), 32'd2);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("release_idle_in_ready",  32'(in_ready),  32'd1);
        chk("release_idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;

        // Abort a frame with reset, then confirm no residue in the next one.
        tv = '{"123", 3, 6'd10, 32'd123, 5'd3, 1'b0, 1'b0, 1'b0};
        send_frame(tv, 2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
        @(posedge clk);
        #1;
        tv = '{"45", 2, 6'd10, 32'd45, 5'd2, 1'b0, 1'b0, 1'b0};
        send_frame(tv, 2);

        for (int w = 0; w < 100 && sb.size() != 0; w++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL missing_results: got %0d pending, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
